// File: rtl/popcount_seq_ctrl_if.sv
// Beat-in / result-out handshake bundle for popcount_seq_ctrl.
// The slave modport is the controller's view; the master modport is the source/consumer side.
interface popcount_seq_ctrl_if #(
  parameter int SLICES = 8,
  parameter int ACC_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [13*SLICES-1:0]  in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_count;
  logic                  out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_ovf
  );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Time-shared popcount sequencer: one 13-input ones-counter walks a wide beat slice by slice,
// accumulating a saturating total across beats until the last beat, then offers it on a valid/ready port.

module adder_13to4 (
  input  logic [12:0] bits_i,
  output logic [3:0]  count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < 13; i++) begin
      count_o = count_o + 4'(bits_i[i]);
    end
  end
endmodule

module popcount_seq_ctrl #(
  parameter int SLICES = 8,
  parameter int ACC_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  popcount_seq_ctrl_if.slave  bus,
  output logic                busy
);
  localparam int DATA_W = 13 * SLICES;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               last_q, last_d;

  logic [3:0]         slice_cnt;
  logic [ACC_W:0]     sum_w;

  logic               in_ready;
  logic               out_valid;
  logic [ACC_W-1:0]   out_count;
  logic               out_ovf;

  // The latched beat shifts down one slice per RUN cycle, so slice idx is always at the bottom.
  adder_13to4 u_cnt (
    .bits_i  (data_q[12:0]),
    .count_o (slice_cnt)
  );

  assign sum_w = {1'b0, acc_q} + {{(ACC_W - 3){1'b0}}, slice_cnt};

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_count = '0;
    out_ovf   = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          last_d  = bus.in_last;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy   = 1'b1;
        data_d = data_q >> 13;
        idx_d  = idx_q + 1'b1;
        if (sum_w[ACC_W]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum_w[ACC_W-1:0];
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = last_q ? S_DONE : S_IDLE;
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_count = acc_q;
        out_ovf   = ovf_q;
        if (bus.out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_count = out_count;
  assign bus.out_ovf   = out_ovf;
endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Bench for popcount_seq_ctrl: a 16-bit and an 8-bit accumulator instance run in lockstep on
// identical stimulus; expected vector totals are queued at drive time and compared at result time.
module tb_popcount_seq_ctrl;
  localparam int SLICES = 8;
  localparam int DW     = 13 * SLICES;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_ready;
  logic          busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int run_total = 0;

  localparam logic [DW-1:0] ONES = '1;

  popcount_seq_ctrl_if #(.SLICES(SLICES), .ACC_W(16)) bus_a ();
  popcount_seq_ctrl_if #(.SLICES(SLICES), .ACC_W(8))  bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  popcount_seq_ctrl #(.SLICES(SLICES), .ACC_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .busy  (busy_a)
  );

  popcount_seq_ctrl #(.SLICES(SLICES), .ACC_W(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .busy  (busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  32'(bus_a.in_ready), 1);
    chk({tag, "_out_valid"}, 32'(bus_a.out_valid), 0);
    chk({tag, "_out_count"}, 32'(bus_a.out_count), 0);
    chk({tag, "_out_ovf"},   32'(bus_a.out_ovf), 0);
    chk({tag, "_busy"},      32'(busy_a), 0);
    chk({tag, "_b_count"},   32'(bus_b.out_count), 0);
    chk({tag, "_b_ready"},   32'(bus_b.in_ready), 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Waits for in_ready, presents one beat for exactly one accepting edge, updates the model.
  task automatic send_beat(input logic [DW-1:0] data, input logic last);
    int n = 0;
    while (bus_a.in_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(bus_a.in_ready), 1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    run_total += $countones(data);
    if (last) begin
      exp_q.push_back(run_total);
      run_total = 0;
    end
  endtask

  // Waits for out_valid, compares against the queued total, holds out_ready low for `hold`
  // cycles (optionally poking a spurious beat), then completes the handshake.
  task automatic get_result(input string tag, input int hold, input bit poke);
    int n = 0;
    int total;
    int exp_a, exp_b;
    logic [15:0] cnt_a;
    logic [7:0]  cnt_b;
    while (bus_a.out_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus_a.out_valid), 1);
    chk({tag, "_sb_entries"}, 32'(exp_q.size()), 1);
    total = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    exp_a = (total > 65535) ? 65535 : total;
    exp_b = (total > 255) ? 255 : total;
    chk({tag, "_count"},   32'(bus_a.out_count), 32'(exp_a));
    chk({tag, "_ovf"},     32'(bus_a.out_ovf), 32'(total > 65535));
    chk({tag, "_b_count"}, 32'(bus_b.out_count), 32'(exp_b));
    chk({tag, "_b_ovf"},   32'(bus_b.out_ovf), 32'(total > 255));
    cnt_a = bus_a.out_count;
    cnt_b = bus_b.out_count;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_data  = ONES;
        in_last  = 1'b1;
      end
      tick();
      chk({tag, "_hold_valid"}, 32'(bus_a.out_valid), 1);
      chk({tag, "_hold_count"}, 32'(bus_a.out_count), 32'(cnt_a));
      chk({tag, "_hold_ovf"},   32'(bus_a.out_ovf), 32'(total > 65535));
      chk({tag, "_hold_b"},     32'(bus_b.out_count), 32'(cnt_b));
      chk({tag, "_hold_ready"}, 32'(bus_a.in_ready), 0);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_after_valid"}, 32'(bus_a.out_valid), 0);
    chk({tag, "_after_ready"}, 32'(bus_a.in_ready), 1);
    chk({tag, "_after_busy"},  32'(busy_a), 0);
  endtask

  initial begin
    logic [DW-1:0] v;

    // Reset state
    do_reset();
    check_reset_values("reset");

    // All-ones last beat: result appears exactly after the 8th slice edge
    send_beat(ONES, 1'b1);
    for (int i = 1; i < SLICES; i++) begin
      tick();
      chk("lat_valid_low", 32'(bus_a.out_valid), 0);
      chk("lat_ready_low", 32'(bus_a.in_ready), 0);
      chk("lat_busy", 32'(busy_a), 1);
    end
    tick();
    chk("lat_valid_high", 32'(bus_a.out_valid), 1);
    get_result("ones", 0, 1'b0);

    // Slice mapping: top bit, bottom bit, alternating pattern
    v = '0;
    v[DW-1] = 1'b1;
    send_beat(v, 1'b1);
    get_result("top_bit", 0, 1'b0);
    v = '0;
    v[0] = 1'b1;
    send_beat(v, 1'b1);
    get_result("bottom_bit", 0, 1'b0);
    send_beat({13{8'hAA}}, 1'b1);
    get_result("alt", 0, 1'b0);

    // Multi-beat: first beat yields no result, in_ready returns after the last slice edge
    send_beat(ONES, 1'b0);
    for (int i = 1; i <= SLICES; i++) begin
      tick();
      chk("mb_no_valid", 32'(bus_a.out_valid), 0);
      chk("mb_ready", 32'(bus_a.in_ready), 32'(i == SLICES));
    end
    send_beat(ONES, 1'b1);
    get_result("multi", 0, 1'b0);

    // Saturation on the 8-bit instance, then a clean follow-up vector
    send_beat(ONES, 1'b0);
    send_beat(ONES, 1'b0);
    send_beat(ONES, 1'b1);
    get_result("sat", 0, 1'b0);
    v = '0;
    v[50] = 1'b1;
    send_beat(v, 1'b1);
    get_result("post_sat", 0, 1'b0);

    // Backpressure for 5 cycles with a spurious beat offered while in_ready is low
    send_beat(ONES, 1'b1);
    get_result("bp", 5, 1'b1);
    send_beat({13{8'h0F}}, 1'b1);
    get_result("after_bp", 0, 1'b0);

    // out_ready already high before and on the first DONE cycle
    out_ready = 1'b1;
    send_beat({13{8'h55}}, 1'b1);
    get_result("early_ready", 0, 1'b0);

    // Reset on the 4th RUN cycle discards the partial sum
    send_beat(ONES, 1'b1);
    void'(exp_q.pop_back());
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy_a), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("mid_rst");
    tick();
    chk("mid_rst_no_valid", 32'(bus_a.out_valid), 0);
    v = '0;
    v[12:0] = 13'h1FFF;
    send_beat(v, 1'b1);
    get_result("slice0", 0, 1'b0);

    // All-zero last beat
    send_beat('0, 1'b1);
    get_result("zero", 0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
